// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared MIDI event and allocator types
package midi_pkg;

    localparam int MIDI_NOTE_W = 7;
    localparam int MIDI_VEL_W  = 7;

    typedef enum logic [1:0] {
        NOTE_OFF = 2'b00,
        NOTE_ON  = 2'b01,
        ALL_OFF  = 2'b10,
        RSVD     = 2'b11
    } evt_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SCAN   = 2'b01,
        COMMIT = 2'b10
    } alloc_state_t;

endpackage

// File: rtl/midi_voice_allocator.sv
// rtl/midi_voice_allocator.sv - note-event to voice-slot allocator (retrigger, free, steal oldest)
module midi_voice_allocator
    import midi_pkg::*;
#(
    parameter int VOICES = 8,
    parameter int AGE_W  = $clog2(VOICES)
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    evt_valid,
    output logic                                    evt_ready,
    input  logic [1:0]                              evt_op,
    input  logic [MIDI_NOTE_W-1:0]                  evt_note,
    input  logic [MIDI_VEL_W-1:0]                   evt_vel,
    output logic [VOICES-1:0]                       voice_active,
    output logic [VOICES-1:0][MIDI_NOTE_W-1:0]      voice_note,
    output logic [VOICES-1:0][MIDI_VEL_W-1:0]       voice_vel,
    output logic [VOICES-1:0]                       voice_load,
    output logic [VOICES-1:0]                       voice_release,
    output logic                                    voice_steal
);

    localparam logic [AGE_W-1:0] LAST_IDX = AGE_W'(VOICES - 1);

    alloc_state_t                   state;
    evt_op_t                        ev_op;
    logic [MIDI_NOTE_W-1:0]         ev_note;
    logic [MIDI_VEL_W-1:0]          ev_vel;
    logic [VOICES-1:0][AGE_W-1:0]   age;

    logic [AGE_W-1:0]               scan_idx;
    logic                           match_ok;
    logic [AGE_W-1:0]               match_idx;
    logic                           free_ok;
    logic [AGE_W-1:0]               free_idx;
    logic                           old_ok;
    logic [AGE_W-1:0]               old_idx;
    logic [AGE_W-1:0]               old_age;

    logic [AGE_W-1:0]               tgt;
    logic                           tgt_stolen;

    assign evt_ready = (state == IDLE);

    // Priority: retrigger the same note, else a free slot, else the oldest active one.
    always_comb begin
        tgt        = old_idx;
        tgt_stolen = 1'b0;
        if (match_ok) begin
            tgt = match_idx;
        end else if (free_ok) begin
            tgt = free_idx;
        end else begin
            tgt_stolen = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ev_op         <= NOTE_OFF;
            ev_note       <= '0;
            ev_vel        <= '0;
            age           <= '0;
            scan_idx      <= '0;
            match_ok      <= 1'b0;
            match_idx     <= '0;
            free_ok       <= 1'b0;
            free_idx      <= '0;
            old_ok        <= 1'b0;
            old_idx       <= '0;
            old_age       <= '0;
            voice_active  <= '0;
            voice_note    <= '0;
            voice_vel     <= '0;
            voice_load    <= '0;
            voice_release <= '0;
            voice_steal   <= 1'b0;
        end else begin
            voice_load    <= '0;
            voice_release <= '0;
            voice_steal   <= 1'b0;
            case (state)
                IDLE: begin
                    if (evt_valid) begin
                        // A note-on with zero velocity is a note-off in MIDI running-status practice.
                        if (evt_op_t'(evt_op) == NOTE_ON && evt_vel == '0) begin
                            ev_op <= NOTE_OFF;
                        end else begin
                            ev_op <= evt_op_t'(evt_op);
                        end
                        ev_note  <= evt_note;
                        ev_vel   <= evt_vel;
                        scan_idx <= '0;
                        match_ok <= 1'b0;
                        free_ok  <= 1'b0;
                        old_ok   <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (voice_active[scan_idx] && voice_note[scan_idx] == ev_note && !match_ok) begin
                        match_ok  <= 1'b1;
                        match_idx <= scan_idx;
                    end
                    if (!voice_active[scan_idx] && !free_ok) begin
                        free_ok  <= 1'b1;
                        free_idx <= scan_idx;
                    end
                    // Strict compare keeps the lowest index on equal ages.
                    if (voice_active[scan_idx] && (!old_ok || age[scan_idx] > old_age)) begin
                        old_ok  <= 1'b1;
                        old_idx <= scan_idx;
                        old_age <= age[scan_idx];
                    end
                    if (scan_idx == LAST_IDX) begin
                        state <= COMMIT;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                COMMIT: begin
                    case (ev_op)
                        NOTE_ON: begin
                            for (int i = 0; i < VOICES; i++) begin
                                if (AGE_W'(i) == tgt) begin
                                    age[i] <= '0;
                                end else if (voice_active[i] && age[i] != LAST_IDX) begin
                                    age[i] <= age[i] + 1'b1;
                                end
                            end
                            voice_active[tgt] <= 1'b1;
                            voice_note[tgt]   <= ev_note;
                            voice_vel[tgt]    <= ev_vel;
                            voice_load[tgt]   <= 1'b1;
                            voice_steal       <= tgt_stolen;
                        end
                        NOTE_OFF: begin
                            if (match_ok) begin
                                voice_active[match_idx]  <= 1'b0;
                                voice_release[match_idx] <= 1'b1;
                            end
                        end
                        ALL_OFF: begin
                            voice_release <= voice_active;
                            voice_active  <= '0;
                        end
                        default: begin
                        end
                    endcase
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb/tb_midi_voice_allocator.sv - directed-vector bench for midi_voice_allocator with 4 voices
module tb_midi_voice_allocator;

    localparam int V = 4;

    logic             clock;
    logic             reset;
    logic             evt_valid;
    logic             evt_ready;
    logic [1:0]       evt_op;
    logic [6:0]       evt_note;
    logic [6:0]       evt_vel;
    logic [V-1:0]     voice_active;
    logic [V-1:0][6:0] voice_note;
    logic [V-1:0][6:0] voice_vel;
    logic [V-1:0]     voice_load;
    logic [V-1:0]     voice_release;
    logic             voice_steal;

    int               vectors;
    int               miscompares;
    logic [5:0]       rdy_hist;

    midi_voice_allocator #(.VOICES(V), .AGE_W(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_op        (evt_op),
        .evt_note      (evt_note),
        .evt_vel       (evt_vel),
        .voice_active  (voice_active),
        .voice_note    (voice_note),
        .voice_vel     (voice_vel),
        .voice_load    (voice_load),
        .voice_release (voice_release),
        .voice_steal   (voice_steal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge of the cycle where the updated table is visible.
    task automatic send(input logic [1:0] op, input int n, input int v);
        int waited;
        waited = 0;
        @(negedge clock);
        while (!evt_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        check("accept_ready", 32'(evt_ready), 1);
        evt_valid = 1'b1;
        evt_op    = op;
        evt_note  = 7'(n);
        evt_vel   = 7'(v);
        @(posedge clock);
        #1 evt_valid = 1'b0;
        rdy_hist = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            rdy_hist[i] = evt_ready;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [V-1:0] load_seen;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        evt_valid   = 1'b0;
        evt_op      = 2'b00;
        evt_note    = '0;
        evt_vel     = '0;
        rdy_hist    = '0;
        repeat (3) @(negedge clock);
        check("rst_ready", 32'(evt_ready), 1);
        check("rst_active", 32'(voice_active), 0);
        check("rst_load", 32'(voice_load), 0);
        reset = 1'b0;

        send(2'b01, 60, 100);
        check("first_ready_hist", 32'(rdy_hist), 32'b100000);
        check("first_active", 32'(voice_active), 32'b0001);
        check("first_note0", 32'(voice_note[0]), 60);
        check("first_vel0", 32'(voice_vel[0]), 100);
        check("first_load", 32'(voice_load), 32'b0001);
        check("first_steal", 32'(voice_steal), 0);
        @(negedge clock);
        check("first_load_1cyc", 32'(voice_load), 0);

        send(2'b01, 62, 90);
        send(2'b01, 64, 80);
        send(2'b01, 67, 70);
        check("fill_active", 32'(voice_active), 32'b1111);
        check("fill_note3", 32'(voice_note[3]), 67);
        send(2'b01, 72, 50);
        check("steal_load", 32'(voice_load), 32'b0001);
        check("steal_pulse", 32'(voice_steal), 1);
        check("steal_note0", 32'(voice_note[0]), 72);
        check("steal_note1", 32'(voice_note[1]), 62);
        check("steal_active", 32'(voice_active), 32'b1111);
        @(negedge clock);
        check("steal_1cyc", 32'(voice_steal), 0);

        do_reset();
        check("rst2_active", 32'(voice_active), 0);
        send(2'b01, 60, 100);
        send(2'b01, 62, 100);
        send(2'b01, 60, 20);
        check("retrig_load", 32'(voice_load), 32'b0001);
        check("retrig_steal", 32'(voice_steal), 0);
        check("retrig_vel0", 32'(voice_vel[0]), 20);
        check("retrig_active", 32'(voice_active), 32'b0011);
        send(2'b01, 64, 100);
        send(2'b01, 67, 100);
        send(2'b01, 72, 100);
        check("retrig_steal_load", 32'(voice_load), 32'b0010);
        check("retrig_steal_pulse", 32'(voice_steal), 1);
        check("retrig_steal_note1", 32'(voice_note[1]), 72);

        do_reset();
        send(2'b01, 60, 100);
        send(2'b01, 62, 100);
        send(2'b01, 64, 100);
        send(2'b01, 67, 100);
        send(2'b00, 62, 0);
        check("off_release", 32'(voice_release), 32'b0010);
        check("off_active", 32'(voice_active), 32'b1101);
        check("off_load", 32'(voice_load), 0);
        send(2'b01, 64, 0);
        check("vel0_release", 32'(voice_release), 32'b0100);
        check("vel0_active", 32'(voice_active), 32'b1001);
        check("vel0_note_kept", 32'(voice_note[2]), 64);
        send(2'b00, 50, 0);
        check("absent_release", 32'(voice_release), 0);
        check("absent_active", 32'(voice_active), 32'b1001);
        send(2'b11, 60, 10);
        check("rsvd_active", 32'(voice_active), 32'b1001);
        check("rsvd_load", 32'(voice_load), 0);
        check("rsvd_vel0", 32'(voice_vel[0]), 100);

        send(2'b01, 70, 30);
        check("hole_fill_load", 32'(voice_load), 32'b0010);
        check("hole_active", 32'(voice_active), 32'b1011);
        send(2'b10, 0, 0);
        check("alloff_release", 32'(voice_release), 32'b1011);
        check("alloff_active", 32'(voice_active), 0);
        @(negedge clock);
        check("alloff_1cyc", 32'(voice_release), 0);
        send(2'b01, 55, 40);
        check("after_alloff_load", 32'(voice_load), 32'b0001);
        check("after_alloff_note0", 32'(voice_note[0]), 55);

        @(negedge clock);
        evt_valid = 1'b1;
        evt_op    = 2'b01;
        evt_note  = 7'd40;
        evt_vel   = 7'd9;
        @(posedge clock);
        #1 evt_valid = 1'b0;
        load_seen = '0;
        repeat (3) begin
            @(negedge clock);
            load_seen |= voice_load;
        end
        reset = 1'b1;
        #1;
        check("midrst_active", 32'(voice_active), 0);
        check("midrst_note0", 32'(voice_note[0]), 0);
        check("midrst_vel0", 32'(voice_vel[0]), 0);
        check("midrst_ready", 32'(evt_ready), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i == 2) reset = 1'b0;
            load_seen |= voice_load;
        end
        check("midrst_no_load", 32'(load_seen), 0);
        send(2'b01, 61, 5);
        check("post_rst_hist", 32'(rdy_hist), 32'b100000);
        check("post_rst_active", 32'(voice_active), 32'b0001);
        check("post_rst_note0", 32'(voice_note[0]), 61);
        check("post_rst_load", 32'(voice_load), 32'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/midi_voice_allocator.md
# midi_voice_allocator

Assigns incoming MIDI note events to a fixed pool of synthesizer voice slots and drives the per-voice configuration (note, velocity, active) consumed by the oscillator/envelope datapath. It sits between the MIDI message parser (downstream of the UART byte deserializer) and the voice bank. It arbitrates the shared voice resource with three rules, in priority order:
- retrigger an existing voice playing the same note
- take a free voice
- steal the oldest active voice

## Interface
- VOICES, 8, number of voice slots (power of two, 2..16)
- AGE_W, $clog2(VOICES), width of per-voice age rank
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- evt_valid  in  1  event offered
- evt_ready  out  1  allocator can accept; equals (state == IDLE)
- evt_op  in  2  00 note-off, 01 note-on, 10 all-notes-off, 11 reserved (consumed, no effect)
- evt_note  in  7  MIDI note number
- evt_vel  in  7  MIDI velocity
- voice_active  out  VOICES  slot sounding
- voice_note  out  VOICES×7  note per slot
- voice_vel  out  VOICES×7  velocity per slot
- voice_load  out  VOICES  1-cycle pulse: slot (re)started, restart phase/envelope
- voice_release  out  VOICES  1-cycle pulse: slot released
- voice_steal  out  1  1-cycle pulse: the load took an active voice with a different note

## Operation
- States: IDLE → SCAN → COMMIT → IDLE.
- **IDLE:** evt_valid && evt_ready at a clock edge latches op/note/vel and moves to SCAN with scan index 0.
- **Note-on normalisation:** note-on with vel == 0 is treated as note-off.
- **SCAN:** exactly VOICES cycles, one slot per cycle (index 0..VOICES-1). It records:
  - the first active slot whose note == evt_note (match)
  - the lowest-index inactive slot (free)
  - the active slot with the largest age; ties go to the lowest index (oldest)
- **COMMIT, note-on:** target = match, else free, else oldest.
  - Target gets note/vel and active=1, and age 0.
  - Every other active slot's age increments, saturating at VOICES-1.
  - voice_load[target] pulses.
  - voice_steal pulses only when target came from oldest.
- **COMMIT, note-off:** if match exists, clear its active bit and pulse voice_release[match]. Note/vel are retained. With no match: no change, no pulse.
- **COMMIT, all-notes-off:** clear every active bit and pulse voice_release for every previously active slot.
- **COMMIT, reserved op:** no effect.
- Inactive slots keep their age; age is only compared among active slots.
- Pulses are registered, high for exactly one cycle, and coincide with the updated table.

## Timing
- Latency: event accepted at edge T → SCAN occupies cycles T+1..T+VOICES → COMMIT at T+VOICES+1 → updated outputs, pulses and evt_ready=1 all at T+VOICES+2.
- Throughput: one event per VOICES+2 cycles. evt_ready=0 throughout SCAN and COMMIT.
- Upstream must hold evt_* stable until accepted. The allocator captures evt_* at acceptance and ignores it afterward.
- Reset (asynchronous, any time, including mid-SCAN/COMMIT) forces:
  - state IDLE
  - voice_active/note/vel/load/release/steal all 0
  - all ages 0
  - the in-flight event discarded with no partial table update
- evt_ready reads 1 during reset. Acceptance occurs only on an edge with reset low.

## Structure
- Shared package midi_pkg holds:
  - evt_op_t enum (NOTE_OFF, NOTE_ON, ALL_OFF, RSVD)
  - alloc_state_t enum (IDLE, SCAN, COMMIT)
  - MIDI_NOTE_W = 7 and MIDI_VEL_W = 7
- The voice table, age array and scan registers live in this module. The scan is a single counter-driven loop, so no sub-module is warranted.

## Test plan
All scenarios use VOICES=4 (latency 6).
- **Reset and single note-on:** release reset, then note-on note=60 vel=100 accepted at T → at T+6 voice_active=0001, voice_note[0]=60, voice_load=0001 for one cycle, evt_ready=1; evt_ready=0 during T+1..T+5.
- **Fill and steal:** note-on 60,62,64,67 → slots 0..3. Then note-on 72 → slot 0 (oldest) loaded with 72, voice_steal=1, others unchanged.
- **Retrigger:** with 60 in slot 0 and 62 in slot 1, note-on 60 vel=20 → slot 0 vel=20, voice_load=0001, voice_steal=0, slot 0 age 0. A following steal with all slots full picks slot 1.
- **Note-off forms:**
  - note-off 62 → voice_release[1] pulse, active bit cleared
  - note-on 64 vel=0 → release of the slot holding 64
  - note-off 50 (absent) → no pulse, table unchanged
- **All-notes-off with holes:** active=1011, op=10 → voice_release=1011 for one cycle, active=0000. A following note-on lands in slot 0.
- **Reset mid-SCAN:** assert reset at T+3 of a note-on → all outputs 0 immediately, no voice_load ever pulses. After release, a new event completes normally with latency 6.
